instr_loader: RTL

Writes program words into the 256 x 16-bit instruction memory from an 8-bit byte stream, so programs can be loaded at run time instead of only through simulation initialisation. It sits between a host byte source (UART receiver or testbench driver) and the instruction memory write port. It holds the CPU off while loading. It also reports a 16-bit additive checksum of the words it wrote.

---
 rtl/instr_loader_if.sv | 29 ++
 rtl/instr_loader.sv | 128 ++++++++++++
 2 files changed

// File: rtl/instr_loader_if.sv
// Byte-stream loader bus: host byte source, load control, and instruction memory write port.
// master = host/testbench side, slave = the loader itself.
interface instr_loader_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [ADDR_WIDTH:0]   len;
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [15:0]           mem_wdata;
    logic                  busy;
    logic                  cpu_hold;
    logic                  done;
    logic [15:0]           checksum;

    modport master (
        output start, base_addr, len, in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata, busy, cpu_hold, done, checksum
    );

    modport slave (
        input  start, base_addr, len, in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata, busy, cpu_hold, done, checksum
    );
endinterface

// File: rtl/instr_loader.sv
// Assembles big-endian byte pairs into 16-bit instruction words, writes them to consecutive
// instruction memory addresses, holds the CPU while loading and keeps an additive checksum.
module instr_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic           clk,
    input  logic           reset,
    instr_loader_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HI    = 3'd1,
        S_LO    = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [ADDR_WIDTH:0]   r_remaining;
    logic [7:0]            r_hi;
    logic [15:0]           r_mem_wdata;
    logic [15:0]           r_checksum;
    logic                  w_in_ready;
    logic                  w_mem_we;
    logic                  w_busy;
    logic                  w_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_mem_we     = 1'b0;
        w_busy       = 1'b1;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (bus.start) begin
                    w_state_next = (bus.len != '0) ? S_HI : S_DONE;
                end
            end
            S_HI: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_next = S_LO;
                end
            end
            S_LO: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                w_mem_we = 1'b1;
                // Exactly one word left means this write is the last one.
                w_state_next = (r_remaining != (ADDR_WIDTH+1)'(1)) ? S_HI : S_DONE;
            end
            S_DONE: begin
                w_done       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_busy       = 1'b0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    // mem_addr/mem_wdata are captured together with the low byte, so they stay put between writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr      <= '0;
            r_mem_addr  <= '0;
            r_remaining <= '0;
            r_hi        <= '0;
            r_mem_wdata <= '0;
            r_checksum  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_addr      <= bus.base_addr;
                        r_remaining <= bus.len;
                        r_checksum  <= '0;
                    end
                end
                S_HI: begin
                    if (bus.in_valid) begin
                        r_hi <= bus.in_data;
                    end
                end
                S_LO: begin
                    if (bus.in_valid) begin
                        r_mem_wdata <= {r_hi, bus.in_data};
                        r_mem_addr  <= r_addr;
                    end
                end
                S_WRITE: begin
                    r_checksum  <= r_checksum + r_mem_wdata;
                    r_remaining <= r_remaining - (ADDR_WIDTH+1)'(1);
                    r_addr      <= r_addr + ADDR_WIDTH'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.mem_we    = w_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.busy      = w_busy;
    assign bus.cpu_hold  = w_busy;
    assign bus.done      = w_done;
    assign bus.checksum  = r_checksum;
endmodule
